uart_ctrl: RTL

Second-generation UART controller: a 16x-oversampled receiver and transmitter, each buffered by its own synchronous FIFO, with a runtime-programmable baud divisor, optional parity, and sticky error reporting. It replaces the fixed-rate, 8-bit, error-blind UART top level. It sits between a byte-oriented host (FSM or soft core) and the board's serial pins.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and timing constants for the uart_ctrl block.
// Parity support is compiled in only when UART_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int START_SAMPLE_TICKS = 7;
    localparam int BIT_TICKS          = 16;

    // Modes 00 and 11 both mean "no parity bit".
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO, 2**W entries of B bits.
// Full/empty are explicit flags so the pointers may wrap freely.
module uart_sync_fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full
);

    logic [B-1:0] mem [0:(2**W)-1];
    logic [W-1:0] wptr, rptr, wptr_succ, rptr_succ;
    logic         do_wr, do_rd;

    // A full FIFO accepts a push only when the same cycle frees a slot.
    assign do_rd     = rd & ~empty;
    assign do_wr     = wr & (~full | do_rd);
    assign wptr_succ = wptr + 1'b1;
    assign rptr_succ = rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (do_wr)
                wptr <= wptr_succ;
            if (do_rd)
                rptr <= rptr_succ;
            case ({do_wr, do_rd})
                2'b10: begin
                    empty <= 1'b0;
                    full  <= (wptr_succ == rptr);
                end
                2'b01: begin
                    full  <= 1'b0;
                    empty <= (rptr_succ == wptr);
                end
                default: ;
            endcase
        end
    end

    assign r_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/uart_ctrl.sv
// 16x-oversampled UART with RX/TX FIFOs, programmable divisor and sticky errors.
// Define UART_PARITY_EN to build in parity generation/checking.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = 16,
    parameter int FIFO_W   = 4
) (
    input  logic                i_clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] i_dvsr,
    input  logic [1:0]          i_parity_mode,
    input  logic                rx,
    input  logic                rd_uart,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    input  logic                i_clr_err,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_empty,
    output logic                rx_full,
    output logic                tx_empty,
    output logic                tx_full,
    output logic                tx,
    output logic                tx_busy,
    output logic                o_frame_err,
    output logic                o_parity_err,
    output logic                o_overrun
);

    localparam logic [DVSR_BIT-1:0] DVSR_ONE = 1;

    // ---------------- baud generator ----------------
    logic [DVSR_BIT-1:0] baud_cnt, dvsr_q, dvsr_lim;
    logic                tick;

    assign dvsr_lim = (dvsr_q == '0) ? DVSR_ONE : dvsr_q;
    assign tick     = (baud_cnt == dvsr_lim - DVSR_ONE);

    // The divisor is re-sampled only at wrap so a period is never cut short.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            baud_cnt <= '0;
            dvsr_q   <= i_dvsr;
        end else if (tick) begin
            baud_cnt <= '0;
            dvsr_q   <= i_dvsr;
        end else begin
            baud_cnt <= baud_cnt + DVSR_ONE;
        end
    end

    // ---------------- rx synchronizer ----------------
    logic rx_meta, rx_s, rx_s_d;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // ---------------- receiver ----------------
    rx_state_e       rx_state, rx_state_n;
    logic [5:0]      rx_scnt, rx_scnt_n;
    logic [2:0]      rx_n, rx_n_n;
    logic [DBIT-1:0] rx_b, rx_b_n;
    logic            rx_push, ferr_set, perr_set;
`ifdef UART_PARITY_EN
    logic [1:0]      rx_pmode, rx_pmode_n;
    logic            rx_pbad, rx_pbad_n;
`endif

    always_ff @(posedge i_clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_scnt  <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
`ifdef UART_PARITY_EN
            rx_pmode <= PAR_NONE;
            rx_pbad  <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_n;
            rx_scnt  <= rx_scnt_n;
            rx_n     <= rx_n_n;
            rx_b     <= rx_b_n;
`ifdef UART_PARITY_EN
            rx_pmode <= rx_pmode_n;
            rx_pbad  <= rx_pbad_n;
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_scnt_n  = rx_scnt;
        rx_n_n     = rx_n;
        rx_b_n     = rx_b;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        perr_set   = 1'b0;
`ifdef UART_PARITY_EN
        rx_pmode_n = rx_pmode;
        rx_pbad_n  = rx_pbad;
`endif
        case (rx_state)
            RX_IDLE: begin
                if (rx_s_d && !rx_s) begin
                    rx_state_n = RX_START;
                    rx_scnt_n  = '0;
`ifdef UART_PARITY_EN
                    rx_pmode_n = i_parity_mode;
                    rx_pbad_n  = 1'b0;
`endif
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_scnt == 6'(START_SAMPLE_TICKS - 1)) begin
                        // A line that is high again by mid-start was a glitch.
                        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                        rx_scnt_n  = '0;
                        rx_n_n     = '0;
                    end else begin
                        rx_scnt_n = rx_scnt + 6'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_scnt == 6'(BIT_TICKS - 1)) begin
                        rx_scnt_n = '0;
                        rx_b_n    = {rx_s, rx_b[DBIT-1:1]};
                        if (rx_n == 3'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state_n = parity_on(rx_pmode) ? RX_PARITY : RX_STOP;
`else
                            rx_state_n = RX_STOP;
`endif
                        end else begin
                            rx_n_n = rx_n + 3'd1;
                        end
                    end else begin
                        rx_scnt_n = rx_scnt + 6'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    if (rx_scnt == 6'(BIT_TICKS - 1)) begin
                        rx_scnt_n  = '0;
                        rx_state_n = RX_STOP;
                        rx_pbad_n  = (^rx_b) ^ rx_s ^ (rx_pmode == PAR_ODD);
                    end else begin
                        rx_scnt_n = rx_scnt + 6'd1;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    if (rx_scnt == 6'(SB_TICK - 1)) begin
                        rx_state_n = RX_IDLE;
                        if (!rx_s) begin
                            ferr_set = 1'b1;
                        end else begin
                            rx_push = 1'b1;
`ifdef UART_PARITY_EN
                            perr_set = rx_pbad;
`endif
                        end
                    end else begin
                        rx_scnt_n = rx_scnt + 6'd1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    uart_sync_fifo #(.B(DBIT), .W(FIFO_W)) u_rx_fifo (
        .clk    (i_clk),
        .reset  (reset),
        .rd     (rd_uart),
        .wr     (rx_push),
        .w_data (rx_b),
        .r_data (r_data),
        .empty  (rx_empty),
        .full   (rx_full)
    );

    // ---------------- transmitter ----------------
    tx_state_e       tx_state, tx_state_n;
    logic [5:0]      tx_scnt, tx_scnt_n;
    logic [2:0]      tx_n, tx_n_n;
    logic [DBIT-1:0] tx_b, tx_b_n, tx_head;
    logic            tx_q, tx_next, tx_done;
`ifdef UART_PARITY_EN
    logic [1:0]      tx_pmode, tx_pmode_n;
    logic            tx_pbit, tx_pbit_n;
`else
    logic            unused_parity_mode;
    assign unused_parity_mode = ^i_parity_mode;
`endif

    always_ff @(posedge i_clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_scnt  <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_pmode <= PAR_NONE;
            tx_pbit  <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_scnt  <= tx_scnt_n;
            tx_n     <= tx_n_n;
            tx_b     <= tx_b_n;
            tx_q     <= tx_next;
`ifdef UART_PARITY_EN
            tx_pmode <= tx_pmode_n;
            tx_pbit  <= tx_pbit_n;
`endif
        end
    end

    // tx_next is the level of the current state; tx_q registers it glitch-free.
    always_comb begin
        tx_state_n = tx_state;
        tx_scnt_n  = tx_scnt;
        tx_n_n     = tx_n;
        tx_b_n     = tx_b;
        tx_next    = 1'b1;
        tx_done    = 1'b0;
`ifdef UART_PARITY_EN
        tx_pmode_n = tx_pmode;
        tx_pbit_n  = tx_pbit;
`endif
        case (tx_state)
            TX_IDLE: begin
                if (tick && !tx_empty) begin
                    tx_state_n = TX_START;
                    tx_scnt_n  = '0;
                    tx_b_n     = tx_head;
`ifdef UART_PARITY_EN
                    tx_pmode_n = i_parity_mode;
                    tx_pbit_n  = (^tx_head) ^ (i_parity_mode == PAR_ODD);
`endif
                end
            end
            TX_START: begin
                tx_next = 1'b0;
                if (tick) begin
                    if (tx_scnt == 6'(BIT_TICKS - 1)) begin
                        tx_state_n = TX_DATA;
                        tx_scnt_n  = '0;
                        tx_n_n     = '0;
                    end else begin
                        tx_scnt_n = tx_scnt + 6'd1;
                    end
                end
            end
            TX_DATA: begin
                tx_next = tx_b[0];
                if (tick) begin
                    if (tx_scnt == 6'(BIT_TICKS - 1)) begin
                        tx_scnt_n = '0;
                        tx_b_n    = {1'b0, tx_b[DBIT-1:1]};
                        if (tx_n == 3'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state_n = parity_on(tx_pmode) ? TX_PARITY : TX_STOP;
`else
                            tx_state_n = TX_STOP;
`endif
                        end else begin
                            tx_n_n = tx_n + 3'd1;
                        end
                    end else begin
                        tx_scnt_n = tx_scnt + 6'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                tx_next = tx_pbit;
                if (tick) begin
                    if (tx_scnt == 6'(BIT_TICKS - 1)) begin
                        tx_state_n = TX_STOP;
                        tx_scnt_n  = '0;
                    end else begin
                        tx_scnt_n = tx_scnt + 6'd1;
                    end
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    if (tx_scnt == 6'(SB_TICK - 1)) begin
                        tx_state_n = TX_IDLE;
                        tx_done    = 1'b1;
                    end else begin
                        tx_scnt_n = tx_scnt + 6'd1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    uart_sync_fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
        .clk    (i_clk),
        .reset  (reset),
        .rd     (tx_done),
        .wr     (wr_uart),
        .w_data (w_data),
        .r_data (tx_head),
        .empty  (tx_empty),
        .full   (tx_full)
    );

    assign tx      = tx_q;
    assign tx_busy = (tx_state != TX_IDLE);

    // ---------------- sticky error flags (set beats clear) ----------------
    always_ff @(posedge i_clk) begin
        if (reset) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= ferr_set | (o_frame_err & ~i_clr_err);
            o_overrun   <= (rx_push & rx_full & ~rd_uart) | (o_overrun & ~i_clr_err);
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (reset)
            o_parity_err <= 1'b0;
        else
            o_parity_err <= perr_set | (o_parity_err & ~i_clr_err);
    end
`else
    logic unused_perr_set;
    assign unused_perr_set = perr_set;
    assign o_parity_err    = 1'b0;
`endif

endmodule
